// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes, FSM encodings
// and the register-file bus types used across the pipeline.
package wb_stage_pkg;

  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] RegDataBus;

  localparam RegAddrBus ZeroReg     = 5'd0;
  localparam logic      WriteEnable = 1'b1;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  localparam logic [0:0] WB_IDLE      = 1'b0;
  localparam logic [0:0] WB_WAIT_LOAD = 1'b1;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks the byte/halfword addressed by byte_off out
// of the raw memory word and extends it; flags misaligned or undecodable loads.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        byte_off_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misalign_err_o
);

  function automatic logic [DATA_W-1:0] ext8(input logic signed [7:0] b, input logic sgn);
    ext8 = sgn ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic signed [15:0] h, input logic sgn);
    ext16 = sgn ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
  endfunction

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  assign byte_sel = rdata_i[{byte_off_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{byte_off_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o         = rdata_i;
    misalign_err_o = 1'b0;
    case (funct3_i)
      LB:  data_o = ext8(byte_sel, 1'b1);
      LBU: data_o = ext8(byte_sel, 1'b0);
      LH: begin
        data_o         = ext16(half_sel, 1'b1);
        misalign_err_o = byte_off_i[0];
      end
      LHU: begin
        data_o         = ext16(half_sel, 1'b0);
        misalign_err_o = byte_off_i[0];
      end
      LW:  misalign_err_o = (byte_off_i != 2'b00);
      // Reserved encodings fall back to a word load but are reported.
      default: misalign_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: sole driver of the register-file write port. Retires ALU
// results immediately and holds MEM off while a load response is outstanding.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic              mem_RegWrite_i,
  input  logic [ADDR_W-1:0] mem_rd_addr_i,
  input  logic              mem_is_load_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [1:0]        mem_byte_off_i,
  input  logic [DATA_W-1:0] mem_alu_result_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [DATA_W-1:0] w_data_o,
  output logic              wb_RegWrite_o,
  output logic [CNT_W-1:0]  wb_count_o,
  output logic              err_o
);

  logic [0:0]        state_p0;
  logic [ADDR_W-1:0] rd_p0;
  logic              rw_p0;
  logic [2:0]        f3_p0;
  logic [1:0]        off_p0;
  logic [DATA_W-1:0] ld_data;
  logic              ld_err;
  logic              accept;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .funct3_i       (f3_p0),
    .byte_off_i     (off_p0),
    .rdata_i        (dmem_rdata_i),
    .data_o         (ld_data),
    .misalign_err_o (ld_err)
  );

  assign mem_ready_o = (state_p0 == WB_IDLE);
  assign accept      = mem_valid_i && mem_ready_o;

  // Stage p0: pending-load context, captured on acceptance of a load
  always_ff @(posedge clk_i) begin
    if (accept && mem_is_load_i) begin
      rd_p0  <= mem_rd_addr_i;
      rw_p0  <= mem_RegWrite_i;
      f3_p0  <= mem_funct3_i;
      off_p0 <= mem_byte_off_i;
    end
  end

  // Stage p1: registered register-file write and FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p0      <= WB_IDLE;
      w_addr_o      <= '0;
      w_data_o      <= '0;
      wb_RegWrite_o <= 1'b0;
      wb_count_o    <= '0;
      err_o         <= 1'b0;
    end else begin
      wb_RegWrite_o <= 1'b0;
      case (state_p0)
        WB_IDLE: begin
          // A response with no load outstanding is a protocol violation.
          if (dmem_rvalid_i) err_o <= 1'b1;
          if (accept) begin
            if (mem_is_load_i) begin
              state_p0 <= WB_WAIT_LOAD;
            end else if (mem_RegWrite_i && (mem_rd_addr_i != ADDR_W'(ZeroReg))) begin
              w_addr_o      <= mem_rd_addr_i;
              w_data_o      <= mem_alu_result_i;
              wb_RegWrite_o <= WriteEnable;
              wb_count_o    <= wb_count_o + CNT_W'(1);
            end
          end
        end
        default: begin
          if (dmem_rvalid_i) begin
            state_p0 <= WB_IDLE;
            if (ld_err) err_o <= 1'b1;
            if (rw_p0 && (rd_p0 != ADDR_W'(ZeroReg))) begin
              w_addr_o      <= rd_p0;
              w_data_o      <= ld_data;
              wb_RegWrite_o <= WriteEnable;
              wb_count_o    <= wb_count_o + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a scoreboard of expected register writes
// plus per-scenario tasks checking handshake, counter and error behaviour.
module tb_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic        mem_RegWrite_i;
  logic [4:0]  mem_rd_addr_i;
  logic        mem_is_load_i;
  logic [2:0]  mem_funct3_i;
  logic [1:0]  mem_byte_off_i;
  logic [31:0] mem_alu_result_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o;
  logic        wb_RegWrite_o;
  logic [31:0] wb_count_o;
  logic        err_o;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk_i = ~clk_i;

  wb_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mem_valid_i      (mem_valid_i),
    .mem_ready_o      (mem_ready_o),
    .mem_RegWrite_i   (mem_RegWrite_i),
    .mem_rd_addr_i    (mem_rd_addr_i),
    .mem_is_load_i    (mem_is_load_i),
    .mem_funct3_i     (mem_funct3_i),
    .mem_byte_off_i   (mem_byte_off_i),
    .mem_alu_result_i (mem_alu_result_i),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .w_addr_o         (w_addr_o),
    .w_data_o         (w_data_o),
    .wb_RegWrite_o    (wb_RegWrite_o),
    .wb_count_o       (wb_count_o),
    .err_o            (err_o)
  );

  // Scoreboard: every write seen must match the oldest expected one.
  always @(negedge clk_i) begin
    if (!rst_i && wb_RegWrite_o) begin
      wr_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", w_addr_o, w_data_o);
      end else begin
        e = exp_q.pop_front();
        if (w_addr_o !== e.addr || w_data_o !== e.data) begin
          n_fail++;
          $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   w_addr_o, w_data_o, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Drives one transfer starting at posedge+1; returns at the next posedge+1.
  task automatic issue(input logic ld, input logic rw, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [1:0] off, input logic [31:0] alu);
    mem_valid_i      = 1'b1;
    mem_is_load_i    = ld;
    mem_RegWrite_i   = rw;
    mem_rd_addr_i    = rd;
    mem_funct3_i     = f3;
    mem_byte_off_i   = off;
    mem_alu_result_i = alu;
    if (!ld && rw && rd != 5'd0) exp_q.push_back('{addr: rd, data: alu});
    @(posedge clk_i);
    #1;
    mem_valid_i = 1'b0;
  endtask

  // Returns dmem response sampled at the next posedge; expected write queued here.
  task automatic respond(input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] exp_data);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    exp_q.push_back('{addr: rd, data: exp_data});
    @(posedge clk_i);
    #1;
    dmem_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (w_addr_o !== 5'd0 || w_data_o !== 32'd0 || wb_RegWrite_o !== 1'b0 ||
        wb_count_o !== 32'd0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%0d data=%h we=%b cnt=%0d err=%b, required all zero",
               w_addr_o, w_data_o, wb_RegWrite_o, wb_count_o, err_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    n_checks++;
    if (mem_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 1", mem_ready_o);
    end
  endtask

  task automatic test_add();
    issue(1'b0, 1'b1, 5'd5, 3'd0, 2'd0, 32'h0000_1234);
    @(negedge clk_i);
    n_checks++;
    if (wb_RegWrite_o !== 1'b1 || w_addr_o !== 5'd5 || w_data_o !== 32'h0000_1234 || wb_count_o !== 32'd1) begin
      n_fail++;
      $display("FAIL add_write: got we=%b addr=%0d data=%h cnt=%0d, required we=1 addr=5 data=00001234 cnt=1",
               wb_RegWrite_o, w_addr_o, w_data_o, wb_count_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_load_lb();
    int low_cycles = 0;
    issue(1'b1, 1'b1, 5'd7, 3'd0, 2'd3, 32'hDEAD_DEAD);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) respond(32'h80FF_0000, 5'd7, 32'hFFFF_FF80);
      else begin
        @(negedge clk_i);
        if (mem_ready_o === 1'b0 && wb_RegWrite_o === 1'b0) low_cycles++;
        @(posedge clk_i);
        #1;
      end
      if (i == 3) low_cycles++;
    end
    n_checks++;
    if (low_cycles != 4) begin
      n_fail++;
      $display("FAIL lb_stall: got %0d stalled idle cycles, required 4", low_cycles);
    end
    @(negedge clk_i);
    n_checks++;
    if (mem_ready_o !== 1'b1 || wb_RegWrite_o !== 1'b1 || wb_count_o !== 32'd2 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_retire: got ready=%b we=%b cnt=%0d err=%b, required ready=1 we=1 cnt=2 err=0",
               mem_ready_o, wb_RegWrite_o, wb_count_o, err_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_load_half();
    issue(1'b1, 1'b1, 5'd8, 3'd5, 2'd2, 32'h0);
    respond(32'hBEEF_1234, 5'd8, 32'h0000_BEEF);
    @(negedge clk_i);
    n_checks++;
    if (err_o !== 1'b0 || wb_RegWrite_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lhu_ok: got err=%b we=%b, required err=0 we=1", err_o, wb_RegWrite_o);
    end
    @(posedge clk_i);
    #1;
    issue(1'b1, 1'b1, 5'd9, 3'd4, 2'd1, 32'h0);
    respond(32'h0000_9A00, 5'd9, 32'h0000_009A);
    issue(1'b1, 1'b1, 5'd10, 3'd2, 2'd0, 32'h0);
    respond(32'hDEAD_BEEF, 5'd10, 32'hDEAD_BEEF);
    @(negedge clk_i);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL aligned_err: got err=%b, required 0", err_o);
    end
    @(posedge clk_i);
    #1;
    issue(1'b1, 1'b1, 5'd11, 3'd1, 2'd1, 32'h0);
    respond(32'h1234_8765, 5'd11, 32'hFFFF_8765);
    @(negedge clk_i);
    n_checks++;
    if (err_o !== 1'b1 || wb_RegWrite_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lh_misalign: got err=%b we=%b, required err=1 we=1", err_o, wb_RegWrite_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_x0();
    logic [31:0] cnt_before;
    cnt_before = wb_count_o;
    issue(1'b0, 1'b1, 5'd0, 3'd0, 2'd0, 32'hCAFE_F00D);
    @(negedge clk_i);
    n_checks++;
    if (wb_RegWrite_o !== 1'b0 || wb_count_o !== cnt_before) begin
      n_fail++;
      $display("FAIL x0_masked: got we=%b cnt=%0d, required we=0 cnt=%0d",
               wb_RegWrite_o, wb_count_o, cnt_before);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_back_to_back();
    int ready_hi = 0;
    int wr_hi    = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (mem_ready_o === 1'b1) ready_hi++;
      issue(1'b0, 1'b1, 5'(12 + i), 3'd0, 2'd0, 32'h1000_0000 + 32'(i));
      mem_valid_i = (i < 3);
      if (wb_RegWrite_o === 1'b1) wr_hi++;
    end
    n_checks++;
    if (ready_hi != 4 || wr_hi != 4) begin
      n_fail++;
      $display("FAIL b2b_stream: got ready_cycles=%0d write_cycles=%0d, required 4 and 4", ready_hi, wr_hi);
    end
    @(negedge clk_i);
    n_checks++;
    if (wb_count_o !== 32'd4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d, required 4", wb_count_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset_mid_load();
    issue(1'b1, 1'b1, 5'd20, 3'd2, 2'd0, 32'h0);
    @(negedge clk_i);
    n_checks++;
    if (mem_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_wait: got ready=%b, required 0", mem_ready_o);
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (mem_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midload_async: got ready=%b, required 1", mem_ready_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h5555_AAAA;
    @(posedge clk_i);
    #1;
    dmem_rvalid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (wb_RegWrite_o !== 1'b0 || err_o !== 1'b1 || mem_ready_o !== 1'b1 || wb_count_o !== 32'd0) begin
      n_fail++;
      $display("FAIL midload_late_rvalid: got we=%b err=%b ready=%b cnt=%0d, required we=0 err=1 ready=1 cnt=0",
               wb_RegWrite_o, err_o, mem_ready_o, wb_count_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i            = 1'b1;
    mem_valid_i      = 1'b0;
    mem_RegWrite_i   = 1'b0;
    mem_rd_addr_i    = '0;
    mem_is_load_i    = 1'b0;
    mem_funct3_i     = '0;
    mem_byte_off_i   = '0;
    mem_alu_result_i = '0;
    dmem_rvalid_i    = 1'b0;
    dmem_rdata_i     = '0;

    test_reset();
    test_add();
    test_load_lb();
    test_load_half();
    test_x0();
    test_back_to_back();
    test_reset_mid_load();

    @(negedge clk_i);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d writes still expected, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage and sole writer of the register file write port (w_addr/w_data/wb_RegWrite).
- Accepts retiring instructions from the MEM stage and waits for variable-latency data-memory load responses.
- Aligns and sign- or zero-extends load data, then drives a single registered write per instruction. The register file's same-cycle ID bypass depends on this write.
- Stalls MEM through a ready handshake while a load is outstanding.

Parameters:
- DATA_W, 32, register/data width.
- ADDR_W, 5, register address width (32 registers, x0 hardwired zero).
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- mem_valid_i  in  1  MEM presents an instruction this cycle.
- mem_ready_o  out  1  stage can accept; transfer occurs when valid and ready are both 1.
- mem_RegWrite_i  in  1  instruction writes rd.
- mem_rd_addr_i  in  ADDR_W  destination register.
- mem_is_load_i  in  1  instruction is a load; result comes from dmem.
- mem_funct3_i  in  3  load type (LB=0, LH=1, LW=2, LBU=4, LHU=5).
- mem_byte_off_i  in  2  load address bits [1:0].
- mem_alu_result_i  in  DATA_W  result for non-loads.
- dmem_rvalid_i  in  1  load response valid (single-cycle pulse).
- dmem_rdata_i  in  DATA_W  raw aligned-word load data.
- w_addr_o  out  ADDR_W  register file write address.
- w_data_o  out  DATA_W  register file write data.
- wb_RegWrite_o  out  1  register file write enable.
- wb_count_o  out  CNT_W  committed-write count.
- err_o  out  1  sticky protocol/decode error.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE.
  - w_addr_o=0, w_data_o=0, wb_RegWrite_o=0, wb_count_o=0, err_o=0.
  - mem_ready_o=1 once reset deasserts.
  - Reset during WAIT_LOAD abandons the load: no write occurs.
- States are IDLE and WAIT_LOAD. mem_ready_o = (state==IDLE), combinational from state.
- IDLE, non-load accepted at edge N:
  - At N+1, w_addr_o/w_data_o = rd/alu_result.
  - wb_RegWrite_o = mem_RegWrite_i && rd!=0, for exactly one cycle.
  - State stays IDLE, so back-to-back accepts give one write per cycle.
- IDLE, load accepted at edge N:
  - Latch rd, RegWrite, funct3, byte_off.
  - Go to WAIT_LOAD. wb_RegWrite_o=0 from N+1 unless a prior write is being retired.
- WAIT_LOAD, dmem_rvalid_i sampled at edge M:
  - At M+1, write the aligned data with the same x0 masking.
  - Return to IDLE. mem_ready_o=1 in cycle M+1.
- Load alignment:
  - LB/LBU select byte[off] and sign/zero-extend.
  - LH/LHU select halfword[off[1]] and extend; off[0]=1 sets err_o.
  - LW ignores off; off!=0 sets err_o.
  - funct3 3/6/7 is treated as LW and sets err_o.
- dmem_rvalid_i in IDLE (including a late response after reset) is ignored and sets err_o.
- wb_RegWrite_o is deasserted every cycle no write is retired. Outputs w_addr_o/w_data_o hold their last value when there is no write.
- wb_count_o increments by 1 on each cycle wb_RegWrite_o is set, and wraps modulo 2^CNT_W.
- err_o is cleared only by reset.

Decomposition:
- Shared defines file:
  - load funct3 codes: LB, LH, LW, LBU, LHU.
  - WB state encodings.
  - existing RegAddrBus, RegDataBus, ZeroReg and WriteEnable.
- One combinational sub-module, load_align: (funct3, byte_off, rdata) -> (data, misalign_err).

Test Plan:
- Reset, then accept ADD with rd=5, result=0x0000_1234, RegWrite=1 -> next cycle wb_RegWrite_o=1, w_addr_o=5, w_data_o=0x1234, wb_count_o=1.
- LB with off=3 to rd=7; rvalid 3 cycles later with rdata=0x80FF_0000 -> mem_ready_o=0 for 4 cycles; write rd=7 data=0xFFFF_FF80 one cycle after rvalid.
- LHU with off=2 and rdata=0xBEEF_1234 -> 0x0000_BEEF. LH with off=1 -> err_o=1, write still occurs.
- Non-load to rd=0 with RegWrite=1 -> wb_RegWrite_o stays 0 and wb_count_o is unchanged.
- Four back-to-back non-loads -> four consecutive write cycles, mem_ready_o constantly 1, wb_count_o=4.
- Assert rst_i mid-WAIT_LOAD, then rvalid arrives after release -> no write occurs, err_o=1, state IDLE.
